// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache / memory slice: line and word types
// and the state encoding of the physical-memory responder.
package lc3b_types;

    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_word;

    // Byte offset bits within a 128-bit line (16 bytes).
    localparam int unsigned LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } pmem_state_t;

endpackage

// File: rtl/pmem_array.sv
// Line storage for pmem_responder: LINES x 128-bit words, one synchronous
// write port and one asynchronous (combinational) read port.
module pmem_array
    import lc3b_types::*;
#(
    parameter int unsigned LINES = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(LINES)-1:0] waddr,
    input  lc3b_line                 wdata,
    input  logic [$clog2(LINES)-1:0] raddr,
    output lc3b_line                 rdata
);

    lc3b_line mem [LINES];

    // Commit a line on the write strobe.
    // NOTE: the storage has no reset branch on purpose; clearing a large
    // array costs a clear sequencer in hardware and the contents are
    // expected to survive a controller reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pmem_responder.sv
// Line-granular physical-memory responder. Accepts a held read/write line
// request, waits DELAY cycles, then pulses pmem_resp for one cycle.
// Writes commit at the edge that ends the RESP cycle; read data is
// registered into pmem_rdata on entry to RESP and held until the next read.
// Optional build macro: PMEM_CHECK_EN adds the sticky pmem_err protocol
// checker port.
module pmem_responder
    import lc3b_types::*;
#(
    parameter int unsigned DELAY = 4,    // 1..15
    parameter int unsigned LINES = 256   // power of 2, 2..4096
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     pmem_read,
    input  logic     pmem_write,
    input  lc3b_word pmem_address,
    input  lc3b_line pmem_wdata,
    output lc3b_line pmem_rdata,
    output logic     pmem_resp
`ifdef PMEM_CHECK_EN
    ,
    output logic     pmem_err
`endif
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned CNT_W = 4;

    pmem_state_t state, next_state;

    logic [CNT_W-1:0] cnt;
    logic             lat_write;
    logic [IDX_W-1:0] lat_idx;
    lc3b_line         lat_wdata;

    logic             req;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] rd_idx;
    lc3b_line         arr_rdata;
    logic             arr_we;
    logic             load_rdata;

    // Bits outside the line index are aliased away by design.
    logic unused_addr;
    assign unused_addr = &{1'b0, pmem_address};

    assign req     = pmem_read | pmem_write;
    assign req_idx = pmem_address[LINE_OFFSET_BITS +: IDX_W];

    // While idle the incoming request addresses the array directly so a
    // DELAY=1 read can be captured in the same cycle it is accepted.
    assign rd_idx = (state == IDLE) ? req_idx : lat_idx;

    // A write commits only in RESP; a reset in that cycle drops it.
    assign arr_we = (state == RESP) && lat_write && !reset;

    assign pmem_resp = (state == RESP);

    pmem_array #(
        .LINES(LINES)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (lat_idx),
        .wdata (lat_wdata),
        .raddr (rd_idx),
        .rdata (arr_rdata)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and read-capture decision.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state = state;
        load_rdata = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = (DELAY == 1) ? RESP : BUSY;
                    load_rdata = (DELAY == 1) && !pmem_write;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = RESP;
                    load_rdata = !lat_write;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latency counter and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            pmem_rdata <= '0;
        end else begin
            if (state == IDLE && req) begin
                cnt <= CNT_W'(DELAY - 1);
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (load_rdata) begin
                pmem_rdata <= arr_rdata;
            end
        end
    end

    // Capture the request on acceptance; write wins when both are high.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            lat_write <= pmem_write;
            lat_idx   <= req_idx;
            lat_wdata <= pmem_wdata;
        end
    end

`ifdef PMEM_CHECK_EN
    logic protocol_bad;

    // Flag a request that changes or drops mid-transaction, or an
    // ambiguous read+write request in IDLE.
    always_comb begin
        protocol_bad = 1'b0;
        if (state == IDLE) begin
            protocol_bad = pmem_read & pmem_write;
        end else begin
            protocol_bad = !req || (pmem_write != lat_write) || (req_idx != lat_idx);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pmem_err <= 1'b0;
        end else if (protocol_bad) begin
            pmem_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: one DELAY=4/LINES=256 instance and
// one DELAY=1/LINES=16 instance. Drivers push expected responses computed
// from a line-array model; negedge monitors pop and compare on pmem_resp.
module tb_pmem_responder;

    localparam int D0 = 4;
    localparam int L0 = 256;
    localparam int D1 = 1;
    localparam int L1 = 16;

    typedef struct {
        bit           is_read;
        bit           known;
        logic [127:0] data;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst0, rd0, wr0, resp0;
    logic [15:0]  addr0;
    logic [127:0] wdata0, rdata0;
    logic         rst1, rd1, wr1, resp1;
    logic [15:0]  addr1;
    logic [127:0] wdata1, rdata1;
`ifdef PMEM_CHECK_EN
    logic err0, err1;
`endif

    pmem_responder #(.DELAY(D0), .LINES(L0)) dut0 (
        .clk          (clk),
        .reset        (rst0),
        .pmem_read    (rd0),
        .pmem_write   (wr0),
        .pmem_address (addr0),
        .pmem_wdata   (wdata0),
        .pmem_rdata   (rdata0),
        .pmem_resp    (resp0)
`ifdef PMEM_CHECK_EN
        ,
        .pmem_err     (err0)
`endif
    );

    pmem_responder #(.DELAY(D1), .LINES(L1)) dut1 (
        .clk          (clk),
        .reset        (rst1),
        .pmem_read    (rd1),
        .pmem_write   (wr1),
        .pmem_address (addr1),
        .pmem_wdata   (wdata1),
        .pmem_rdata   (rdata1),
        .pmem_resp    (resp1)
`ifdef PMEM_CHECK_EN
        ,
        .pmem_err     (err1)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: plain line arrays plus "contents known" flags.
    logic [127:0] model [2][L0];
    bit           known [2][L0];
    logic [127:0] last_rd [2];
    bit           last_known [2];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int k, input bit r, input bit w, input logic [15:0] a, input logic [127:0] d);
        if (k == 0) begin
            rd0 = r; wr0 = w; addr0 = a; wdata0 = d;
        end else begin
            rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Issue one request on instance k and hold it until pmem_resp.
    // drop_at != 0 releases the request that many cycles after issue.
    task automatic issue(input int k, input bit r, input bit w, input logic [15:0] a,
                         input logic [127:0] d, input int drop_at);
        exp_t e;
        int   idx;
        int   c0;
        bit   seen;
        @(negedge clk);
        c0  = cyc;
        idx = (int'(a) >> 4) % ((k == 0) ? L0 : L1);
        e.is_read = !w;
        e.due     = c0 + ((k == 0) ? D0 : D1);
        if (w) begin
            e.data  = last_rd[k];
            e.known = last_known[k];
            model[k][idx] = d;
            known[k][idx] = 1'b1;
        end else begin
            e.data  = model[k][idx];
            e.known = known[k][idx];
            last_rd[k]    = e.data;
            last_known[k] = e.known;
        end
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        drive(k, r, w, a, d);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (drop_at != 0 && cyc == c0 + drop_at) drive(k, 1'b0, 1'b0, a, d);
            seen = (k == 0) ? (resp0 === 1'b1) : (resp1 === 1'b1);
        end
        @(posedge clk);
        #1;
        drive(k, 1'b0, 1'b0, 16'h0, 128'h0);
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL resp%0d_timeout: got no resp expected resp at cycle %0d", k, e.due);
        end
    endtask

    // Start a write, reset in its second BUSY cycle, confirm nothing completes.
    task automatic abort_write(input logic [15:0] a, input logic [127:0] d);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, a, d);
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 128'h0);
        @(negedge clk);
        check("rdata0_in_reset", rdata0, 128'h0);
        check("resp0_in_reset", {127'h0, resp0}, 128'h0);
        rst0 = 1'b0;
        last_rd[0]    = 128'h0;
        last_known[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("resp0_after_reset", {127'h0, resp0}, 128'h0);
        end
    endtask

    // Monitor for instance 0.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (resp0 === 1'b1) begin
            if (q0.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL resp0_unexpected: got resp at cycle %0d expected none", cyc);
            end else begin
                e = q0.pop_front();
                check("resp0_cycle", 128'(unsigned'(cyc)), 128'(unsigned'(e.due)));
                if (e.known) check(e.is_read ? "rdata0_read" : "rdata0_hold", rdata0, e.data);
            end
        end
    end

    // Monitor for instance 1.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (resp1 === 1'b1) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL resp1_unexpected: got resp at cycle %0d expected none", cyc);
            end else begin
                e = q1.pop_front();
                check("resp1_cycle", 128'(unsigned'(cyc)), 128'(unsigned'(e.due)));
                if (e.known) check(e.is_read ? "rdata1_read" : "rdata1_hold", rdata1, e.data);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [127:0] line_a, line_b, old_line;
        logic [15:0]  a;
        int           k;

        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < L0; i++) begin
                model[j][i] = 128'h0;
                known[j][i] = 1'b0;
            end
            last_rd[j]    = 128'h0;
            last_known[j] = 1'b1;
        end

        rst0 = 1'b1;
        rst1 = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 128'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 128'h0);
        repeat (3) @(negedge clk);
        check("rdata0_reset", rdata0, 128'h0);
        check("resp0_reset", {127'h0, resp0}, 128'h0);
        check("rdata1_reset", rdata1, 128'h0);
        check("resp1_reset", {127'h0, resp1}, 128'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;
`ifdef PMEM_CHECK_EN
        check("err0_reset", {127'h0, err0}, 128'h0);
`endif

        // Basic write then read of the same line through a different offset.
        issue(0, 1'b0, 1'b1, 16'h0040, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0);
        issue(0, 1'b1, 1'b0, 16'h004C, 128'h0, 0);

        // DELAY=1: write-back, then read of a never-written line, then idle.
        issue(1, 1'b0, 1'b1, 16'h0030, {4{$urandom}}, 0);
        issue(1, 1'b1, 1'b0, 16'h0070, 128'h0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("resp1_idle", {127'h0, resp1}, 128'h0);
        end

        // Index aliasing: 0x1000 and 0x0000 share line 0 with 256 lines.
        line_a = {4{32'hAAAA_0001}};
        line_b = {4{32'hBBBB_0002}};
        issue(0, 1'b0, 1'b1, 16'h1000, line_a, 0);
        issue(0, 1'b0, 1'b1, 16'h0000, line_b, 0);
        issue(0, 1'b1, 1'b0, 16'h1000, 128'h0, 0);

        // Read and write both high: treated as a write.
        issue(0, 1'b1, 1'b1, 16'h0080, {128{1'b1}}, 0);
        issue(0, 1'b1, 1'b0, 16'h0080, 128'h0, 0);
`ifdef PMEM_CHECK_EN
        check("err0_both_high", {127'h0, err0}, 128'h1);
        repeat (3) @(negedge clk);
        check("err0_sticky", {127'h0, err0}, 128'h1);
`endif

        // Reset aborts an in-flight write; old contents survive.
        old_line = {4{32'h5A5A_1234}};
        issue(0, 1'b0, 1'b1, 16'h0100, old_line, 0);
        abort_write(16'h0100, {16{8'hAA}});
`ifdef PMEM_CHECK_EN
        check("err0_cleared", {127'h0, err0}, 128'h0);
`endif
        issue(0, 1'b1, 1'b0, 16'h0100, 128'h0, 0);

        // Initiator drops the read in cycle 2; resp must still arrive.
        issue(0, 1'b1, 1'b0, 16'h0040, 128'h0, 2);
`ifdef PMEM_CHECK_EN
        check("err0_drop", {127'h0, err0}, 128'h1);
`endif

        // Randomized traffic on both instances over a small aliased line pool.
        for (int n = 0; n < 60; n++) begin
            k = (n % 3 == 2) ? 1 : 0;
            a = {4'($urandom), 4'b0000, 4'($urandom_range(0, 7)), 4'($urandom)};
            if ($urandom_range(0, 1) == 1)
                issue(k, 1'b0, 1'b1, a, {$urandom, $urandom, $urandom, $urandom}, 0);
            else
                issue(k, 1'b1, 1'b0, a, 128'h0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        check("q0_drained", 128'(q0.size()), 128'h0);
        check("q1_drained", 128'(q1.size()), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
